// File: rtl/counter_pkg.sv
// Shared encodings and defaults for the up/down counter datapath and its control unit.
package counter_pkg;

  localparam logic OP_INC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  // Digit selects are stored as the active-low anode pattern: an[0]=units, an[1]=tens
  localparam logic [1:0] DIG_UNITS = 2'b10;
  localparam logic [1:0] DIG_TENS  = 2'b01;

  localparam int DEFAULT_MAX         = 99;
  localparam int DEFAULT_REFRESH_DIV = 50000;

endpackage

// File: rtl/updown_datapath_if.sv
// Command/status bundle between the counter control FSM (master) and the datapath (slave).
interface updown_datapath_if #(
  parameter int WIDTH = 7
);

  logic             op;
  logic             c_clr;
  logic             c_ld;
  logic [WIDTH-1:0] count;
  logic             z;
  logic             m;
  logic             cmd_err;

  modport master (output op, c_clr, c_ld, input count, z, m, cmd_err);
  modport slave  (input op, c_clr, c_ld, output count, z, m, cmd_err);

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; seg[6]=a .. seg[0]=g, 10..15 blank.
module seg7_decoder (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (bcd)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/updown_datapath.sv
// Saturating up/down count register with zero/max flags, sticky command error and
// a two-digit multiplexed 7-segment display driver.
module updown_datapath
  import counter_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int MAX         = DEFAULT_MAX,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic              clk,
  input  logic              reset,
  updown_datapath_if.slave  bus,
  output logic [6:0]        seg,
  output logic [1:0]        an
);

  localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIV_W  = (WIDTH > 4) ? WIDTH : 4;

  // Returns {illegal, next}: a step past either limit holds the value and flags it.
  function automatic logic [WIDTH:0] sat_step(input logic [WIDTH-1:0] cur, input logic dir);
    if (dir == OP_INC)
      return (cur < WIDTH'(MAX)) ? {1'b0, cur + 1'b1} : {1'b1, cur};
    else
      return (cur != '0) ? {1'b0, cur - 1'b1} : {1'b1, cur};
  endfunction

  logic [WIDTH-1:0]  count_q;
  logic              err_q;
  logic [WIDTH:0]    step;
  logic [SCAN_W-1:0] scan_q;
  logic [1:0]        an_q;
  logic [DIV_W-1:0]  count_ext;
  logic [DIV_W-1:0]  tens;
  logic [DIV_W-1:0]  units;
  logic [3:0]        digit;
  logic [6:0]        dec_seg;
  logic              blank;

  assign step = sat_step(count_q, bus.op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (bus.c_clr) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (bus.c_ld) begin
      count_q <= step[WIDTH-1:0];
      if (step[WIDTH]) err_q <= 1'b1;
    end
  end

  assign bus.count   = count_q;
  assign bus.z       = (count_q == '0);
  assign bus.m       = (count_q == WIDTH'(MAX));
  assign bus.cmd_err = err_q;

  // Digit scan: the anode register doubles as the digit select so an and seg move together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q <= '0;
      an_q   <= DIG_UNITS;
    end else if (scan_q == SCAN_W'(REFRESH_DIV - 1)) begin
      scan_q <= '0;
      an_q   <= ~an_q;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  assign count_ext = DIV_W'(count_q);
  assign tens      = count_ext / DIV_W'(10);
  assign units     = count_ext % DIV_W'(10);
  assign digit     = (an_q == DIG_UNITS) ? 4'(units) : 4'(tens);
  assign blank     = (an_q == DIG_TENS) && (tens == '0);

  seg7_decoder u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  assign seg = blank ? 7'b1111111 : dec_seg;
  assign an  = an_q;

endmodule

// File: tb/tb_updown_datapath.sv
// Bench for updown_datapath: behavioural model with per-cycle compare plus literal scenario checks.
module tb_updown_datapath;

  localparam int W   = 7;
  localparam int MX  = 99;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg;
  logic [1:0] an;

  updown_datapath_if #(.WIDTH(W)) bus ();

  updown_datapath #(.WIDTH(W), .MAX(MX), .REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_count = 0;
  bit m_err   = 0;
  int m_cyc   = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0b%0b) expected %0d (0b%0b) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count = 0;
      m_err   = 0;
      m_cyc   = 0;
    end else begin
      if (bus.c_clr) begin
        m_count = 0;
        m_err   = 0;
      end else if (bus.c_ld) begin
        if (bus.op == 1'b0) begin
          if (m_count < MX) m_count = m_count + 1; else m_err = 1;
        end else begin
          if (m_count > 0) m_count = m_count - 1; else m_err = 1;
        end
      end
      m_cyc = m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    logic [1:0] e_an;
    logic [6:0] e_seg;
    e_an = ((m_cyc / DIV) % 2 == 0) ? 2'b10 : 2'b01;
    if (e_an == 2'b10) e_seg = seg_of(m_count % 10);
    else e_seg = (m_count / 10 == 0) ? 7'b1111111 : seg_of(m_count / 10);
    chk("mdl_count", int'(bus.count), m_count);
    chk("mdl_z", int'(bus.z), int'(m_count == 0));
    chk("mdl_m", int'(bus.m), int'(m_count == MX));
    chk("mdl_err", int'(bus.cmd_err), int'(m_err));
    chk("mdl_an", int'(an), int'(e_an));
    chk("mdl_seg", int'(seg), int'(e_seg));
  end

  task automatic cyc(input logic clr, input logic ld, input logic o);
    @(negedge clk);
    bus.c_clr = clr;
    bus.c_ld  = ld;
    bus.op    = o;
  endtask

  task automatic load_value(input int v);
    cyc(1, 0, 0);
    repeat (v) cyc(0, 1, 0);
    cyc(0, 0, 0);
  endtask

  task automatic wait_an(input logic [1:0] want, input string nm);
    int i;
    i = 0;
    while (an != want && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk(nm, int'(an), int'(want));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    bus.c_clr = 0;
    bus.c_ld  = 0;
    bus.op    = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_z", int'(bus.z), 1);
    chk("rst_an", int'(an), 2);
    chk("rst_seg", int'(seg), 7'b0000001);

    // Five increments then five decrements
    repeat (5) begin cyc(0, 1, 0); cyc(0, 0, 0); end
    chk("inc5_count", int'(bus.count), 5);
    chk("inc5_z", int'(bus.z), 0);
    repeat (5) begin cyc(0, 1, 1); cyc(0, 0, 0); end
    chk("dec5_count", int'(bus.count), 0);
    chk("dec5_z", int'(bus.z), 1);

    // Ramp to MAX, overflow attempt, clear
    repeat (99) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("ramp_count", int'(bus.count), 99);
    chk("ramp_m", int'(bus.m), 1);
    cyc(0, 1, 0); cyc(0, 0, 0);
    chk("ovf_count", int'(bus.count), 99);
    chk("ovf_err", int'(bus.cmd_err), 1);
    cyc(1, 0, 0); cyc(0, 0, 0);
    chk("clr_count", int'(bus.count), 0);
    chk("clr_err", int'(bus.cmd_err), 0);

    // Clear beats load in the same cycle
    load_value(7);
    cyc(1, 1, 0); cyc(0, 0, 0);
    chk("clrwins_count", int'(bus.count), 0);

    // Decrement at zero
    cyc(0, 1, 1); cyc(0, 0, 0);
    chk("udf_count", int'(bus.count), 0);
    chk("udf_z", int'(bus.z), 1);
    chk("udf_err", int'(bus.cmd_err), 1);

    // Display of 37 and blanking with 5
    load_value(37);
    wait_an(2'b01, "d37_an_tens");
    chk("d37_seg_tens", int'(seg), 7'b0000110);
    wait_an(2'b10, "d37_an_units");
    chk("d37_seg_units", int'(seg), 7'b0001111);
    load_value(5);
    wait_an(2'b01, "d5_an_tens");
    chk("d5_seg_blank", int'(seg), 7'b1111111);

    // Randomized commands: balanced phase, then an up-biased phase to reach MAX
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(15) == 0), ($urandom_range(3) != 0), $urandom_range(1));
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(63) == 0), ($urandom_range(3) != 0), ($urandom_range(3) == 0));

    // Asynchronous reset mid-operation at 42
    load_value(42);
    chk("pre_rst_count", int'(bus.count), 42);
    #2 reset = 1;
    #1;
    chk("arst_count", int'(bus.count), 0);
    chk("arst_z", int'(bus.z), 1);
    chk("arst_m", int'(bus.m), 0);
    chk("arst_err", int'(bus.cmd_err), 0);
    chk("arst_an", int'(an), 2);
    chk("arst_seg", int'(seg), 7'b0000001);
    @(negedge clk);
    #2 reset = 0;
    repeat (12) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("post_rst_count", int'(bus.count), 12);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_datapath.md
Name: updown_datapath

Overview:
- Datapath for the up/down counter.
- Executes the control unit's commands `op`, `c_clr` and `c_ld` on a saturating count register, and returns the status flags `z` (zero) and `m` (max).
- Also drives a two-digit multiplexed 7-segment display of the count.
- Sits between the counter control FSM and the board display pins.

Parameters:
- WIDTH, 7: count register width. WIDTH must satisfy 2**WIDTH > MAX.
- MAX, 99: upper count limit, 1..99. Bounded to two decimal digits.
- REFRESH_DIV, 50000: clock cycles per display digit slot.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- op  input  1  0 = increment, 1 = decrement; meaningful only when c_ld=1
- c_clr  input  1  synchronous clear of count register
- c_ld  input  1  load count with count±1 per op
- count  output  WIDTH  current count value
- z  output  1  count == 0
- m  output  1  count == MAX
- cmd_err  output  1  sticky: illegal load attempted
- seg  output  7  segments a..g, active-low, current digit
- an  output  2  digit enables, active-low; an[0]=units, an[1]=tens

Behaviour:
- Reset (asynchronous, any cycle, including mid-scan) sets:
  - count=0, cmd_err=0, scan counter=0, digit select=units.
  - Therefore z=1, m=0, an=2'b10, seg=pattern for "0".
- Count register, evaluated per rising edge in this priority:
  1. c_clr=1: count←0 and cmd_err←0, regardless of c_ld/op.
  2. c_ld=1, op=0, count<MAX: count←count+1.
  3. c_ld=1, op=1, count>0: count←count−1.
  4. c_ld=1, op=0, count==MAX: count holds, cmd_err←1 (no wrap).
  5. c_ld=1, op=1, count==0: count holds, cmd_err←1 (no wrap).
  6. Otherwise: count holds.
- Status flags:
  - z and m are combinational decodes of the count register.
  - They are valid the same cycle the register updates: zero latency after the load edge.
  - The control FSM samples them one state later.
- c_ld asserted for N consecutive cycles steps the count N times; the datapath does no edge detection.
- cmd_err stays high until c_clr or reset.
- Display:
  - tens = count/10, units = count%10, computed combinationally from count.
  - The scan counter counts 0..REFRESH_DIV−1; on wrap the digit select toggles.
  - an is registered, so an and seg change on the same edge.
  - Tens digit blanking: when tens==0, showing the tens digit drives seg=7'b1111111 but keeps an[1]=0.
  - A count change mid-slot updates seg immediately; the scan continues undisturbed.
- No internal state machine beyond the 2-phase digit scan; all control decisions belong to the control unit.

Decomposition:
- Shared package/header `counter_pkg`:
  - Command encodings OP_INC=1'b0, OP_DEC=1'b1.
  - Digit select constants DIG_UNITS, DIG_TENS.
  - Default MAX and REFRESH_DIV.
- One sub-module: `seg7_decoder`, combinational 4-bit BCD to active-low 7-segment.
  - Values 10–15 decode to all-off.
  - Instantiated once on the muxed digit.

Test Plan:
- Assert reset mid-operation at count=42, asynchronous, between edges:
  - count=0, z=1, m=0, cmd_err=0 immediately, before the next clk edge.
  - an=2'b10, seg=7'b0000001 (a..g order).
- 5 single-cycle c_ld pulses with op=0 from 0:
  - count=5 after 5th edge, z=0.
  - Then 5 pulses with op=1: count=0, z=1 on the edge of the 5th pulse.
- Ramp to 99 with MAX=99:
  - m=1 on the 99th load edge.
  - One further c_ld, op=0: count stays 99, cmd_err=1.
  - Then c_clr=1: count=0, cmd_err=0.
- At count=7, drive c_clr=1, c_ld=1, op=0 in the same cycle → count=0 (clear wins).
- Decrement at 0: c_ld=1, op=1 → count stays 0, z=1, cmd_err=1.
- Display scan with REFRESH_DIV=4, count=37:
  - an toggles every 4 cycles between 10 (units, seg="7") and 01 (tens, seg="3").
  - count=5 gives a tens slot with seg=7'b1111111.
